// File: rtl/fadd_issue.sv
// fadd_issue: issue/collect stage around the 2-stage pipelined fadd adder with credit-based issue and an in-order result FIFO
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : request handshake; in_op 0 = add, 1 = sub; in_a/in_b IEEE-754 single; in_tag opaque tag
//   fadd_x1/fadd_x2   : operands to fadd (zero when no request is accepted)
//   fadd_y/fadd_ovf   : fadd result, valid LAT edges after its operands
//   out_valid/out_ready, out_data, out_ovf, out_tag : head of the result FIFO
//   FSUB_EN           : when defined, in_op = 1 negates B; otherwise in_op is ignored
module fadd_issue #(
  parameter int TAG_W = 5,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      fadd_x1,
  output logic [31:0]      fadd_x2,
  input  logic [31:0]      fadd_y,
  input  logic             fadd_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic             w_fire;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_b_eff;
  logic [31:0]      w_used;
  logic [LAT-1:0]   r_pv;
  logic [TAG_W-1:0] r_pt [LAT];
  logic [31:0]      r_my [DEPTH];
  logic [DEPTH-1:0] r_mo;
  logic [TAG_W-1:0] r_mt [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_count;
`ifdef FSUB_EN
  assign w_b_eff = in_op ? {~in_b[31], in_b[30:0]} : in_b;
`else
  logic w_unused_op;
  assign w_unused_op = in_op;
  assign w_b_eff = in_b;
`endif
  // fadd cannot stall, so every op in flight already owns a FIFO slot
  always_comb begin
    w_used = 32'(r_count);
    for (int k = 0; k < LAT; k++) w_used = w_used + 32'(r_pv[k]);
  end
  assign in_ready = !rst && (w_used < 32'(DEPTH));
  assign w_fire   = in_valid && in_ready;
  assign fadd_x1  = w_fire ? in_a : '0;
  assign fadd_x2  = w_fire ? w_b_eff : '0;
  // tail of this shift register lines up with fadd_y/fadd_ovf
  always_ff @(posedge clk) begin
    if (rst) r_pv <= '0;
    else begin
      r_pv[0] <= w_fire;
      for (int k = 1; k < LAT; k++) r_pv[k] <= r_pv[k-1];
    end
    r_pt[0] <= in_tag;
    for (int k = 1; k < LAT; k++) r_pt[k] <= r_pt[k-1];
  end
  assign w_push = r_pv[LAT-1];
  assign w_pop  = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_mo    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_my[i] <= '0;
        r_mt[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_my[r_wp] <= fadd_y;
        r_mo[r_wp] <= fadd_ovf;
        r_mt[r_wp] <= r_pt[LAT-1];
        r_wp       <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  assign out_valid = r_count != '0;
  assign out_data  = r_my[r_rp];
  assign out_ovf   = r_mo[r_rp];
  assign out_tag   = r_mt[r_rp];
endmodule

// File: tb/tb_fadd_issue.sv
// tb_fadd_issue: directed self-checking bench for fadd_issue with a behavioural 2-stage fadd
module tb_fadd_issue;
  logic        clk, rst, in_valid, in_ready, in_op, fadd_ovf, out_valid, out_ready, out_ovf;
  logic [31:0] in_a, in_b, fadd_x1, fadd_x2, fadd_y, out_data;
  logic [4:0]  in_tag, out_tag;
  int n_chk = 0, n_err = 0, cyc = 0, ov_cnt = 0;
  logic [31:0] q_y[$];
  logic        q_o[$];
  logic [4:0]  q_t[$];
  int          q_c[$];
  fadd_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .fadd_x1(fadd_x1), .fadd_x2(fadd_x2),
    .fadd_y(fadd_y), .fadd_ovf(fadd_ovf), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_tag(out_tag)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // adder model good for small integer-valued floats plus the max+max overflow case
  function automatic int f2i(input logic [31:0] f);
    int sh;
    logic [31:0] m;
    if (f[30:23] == 8'd0) return 0;
    sh = int'(f[30:23]) - 127;
    m = {8'd0, 1'b1, f[22:0]} >> (23 - sh);
    return f[31] ? -int'(m) : int'(m);
  endfunction
  function automatic logic [31:0] i2f(input int n);
    logic [31:0] a;
    int p;
    if (n == 0) return 32'd0;
    a = (n < 0) ? 32'(-n) : 32'(n);
    p = 0;
    for (int k = 0; k < 31; k++) if (a[k]) p = k;
    a = a << (23 - p);
    return {n < 0, 8'(127 + p), a[22:0]};
  endfunction
  function automatic logic [32:0] fm(input logic [31:0] x1, input logic [31:0] x2);
    if (x1 == 32'h7F7FFFFF && x2 == 32'h7F7FFFFF) return {1'b1, 32'h7F800000};
    return {1'b0, i2f(f2i(x1) + f2i(x2))};
  endfunction
  logic [32:0] s1, s2;
  always @(posedge clk)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= fm(fadd_x1, fadd_x2);
      s2 <= s1;
    end
  assign {fadd_ovf, fadd_y} = s2;
  always @(negedge clk) begin
    if (out_valid) ov_cnt++;
    if (!rst && out_valid && out_ready) begin
      q_y.push_back(out_data);
      q_o.push_back(out_ovf);
      q_t.push_back(out_tag);
      q_c.push_back(cyc);
    end
    if (!rst && dut.w_push) chk("fifo_push_full", 64'(dut.r_count == 3'd4), 64'd0);
  end
  task automatic clrq();
    q_y.delete(); q_o.delete(); q_t.delete(); q_c.delete();
  endtask
  task automatic wait_res(input int n);
    int g = 0;
    while (q_y.size() < n && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (q_y.size() < n) chk("result_timeout", 64'(q_y.size()), 64'(n));
  endtask
  task automatic single(input string nm, input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [4:0] tag, input logic [31:0] xb, input logic [31:0] ey, input logic eo);
    int acc;
    in_valid = 1; in_a = a; in_b = b; in_op = op; in_tag = tag; #1;
    chk({nm, "_rdy"}, 64'(in_ready), 64'd1);
    chk({nm, "_x1"}, 64'(fadd_x1), 64'(a));
    chk({nm, "_x2"}, 64'(fadd_x2), 64'(xb));
    acc = cyc;
    @(posedge clk); #1;
    in_valid = 0; #1;
    chk({nm, "_bubble"}, 64'(fadd_x1), 64'd0);
    wait_res(1);
    if (q_y.size() > 0) begin
      chk({nm, "_data"}, 64'(q_y[0]), 64'(ey));
      chk({nm, "_ovf"}, 64'(q_o[0]), 64'(eo));
      chk({nm, "_tag"}, 64'(q_t[0]), 64'(tag));
      chk({nm, "_lat"}, 64'(q_c[0] - acc), 64'd3);
    end
    clrq();
  endtask
  task automatic feed(input int n, input int base, output int stalls);
    int idx = 0, g = 0;
    logic r;
    stalls = 0;
    while (idx < n && g < 200) begin
      in_valid = 1; in_a = i2f(base + idx); in_b = 32'h3F800000; in_op = 0; in_tag = 5'(idx); #1;
      r = in_ready;
      if (!r) stalls++;
      @(posedge clk); #1;
      if (r) idx++;
      g++;
    end
    in_valid = 0;
    if (idx < n) chk("feed_timeout", 64'(idx), 64'(n));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  logic [31:0] bp_a [6] = '{32'h0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
  logic [31:0] bp_y [6] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
  initial begin
    int idx, st, ov0;
    logic r;
    rst = 1; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_tag = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1; in_a = 32'h3F800000; in_b = 32'h40000000; #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_x1", 64'(fadd_x1), 64'd0);
    chk("rst_x2", 64'(fadd_x2), 64'd0);
    in_valid = 0;
    @(posedge clk); #1;
    rst = 0; #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    single("add", 32'h3F800000, 32'h40000000, 1'b0, 5'd3, 32'h40000000, 32'h40400000, 1'b0);
`ifdef FSUB_EN
    single("sub", 32'h40400000, 32'h3F800000, 1'b1, 5'd7, 32'hBF800000, 32'h40000000, 1'b0);
`else
    single("sub", 32'h40400000, 32'h3F800000, 1'b1, 5'd7, 32'h3F800000, 32'h40800000, 1'b0);
`endif
    single("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 5'd9, 32'h7F7FFFFF, 32'h7F800000, 1'b1);
    out_ready = 0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      in_valid = 1; in_a = bp_a[idx]; in_b = 32'h3F800000; in_op = 0; in_tag = 5'(idx); #1;
      if (c == 10) begin
        chk("bp_accepted", 64'(idx), 64'd4);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_head_tag", 64'(out_tag), 64'd0);
        out_ready = 1; #1;
      end
      r = in_ready;
      @(posedge clk); #1;
      if (r) idx++;
    end
    in_valid = 0;
    wait_res(6);
    if (q_y.size() >= 6)
      for (int i = 0; i < 6; i++) begin
        chk("bp_tag", 64'(q_t[i]), 64'(i));
        chk("bp_data", 64'(q_y[i]), 64'(bp_y[i]));
      end
    clrq();
    feed(16, 0, st);
    chk("stream_stalls", 64'(st), 64'd0);
    wait_res(16);
    if (q_y.size() >= 16) begin
      for (int i = 0; i < 16; i++) begin
        chk("stream_data", 64'(q_y[i]), 64'(i2f(i + 1)));
        chk("stream_tag", 64'(q_t[i]), 64'(i));
      end
      chk("stream_last", 64'(q_y[15]), 64'h41800000);
      chk("stream_span", 64'(q_c[15] - q_c[0]), 64'd15);
    end
    repeat (3) @(posedge clk);
    #1;
    clrq();
    ov0 = ov_cnt;
    feed(2, 1, st);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; #1;
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_rst_no_valid", 64'(ov_cnt - ov0), 64'd0);
    chk("mid_rst_no_result", 64'(q_y.size()), 64'd0);
    single("fresh", 32'h3F800000, 32'h40000000, 1'b0, 5'd5, 32'h40000000, 32'h40400000, 1'b0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
